// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave bus between N masters; ownership held while owner cyc is high.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_master_arbiter #(
    parameter int unsigned N_MASTERS      = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                             wb_clk_i,
    input  logic                             rst_i,
    input  logic [N_MASTERS-1:0]             m_cyc_i,
    input  logic [N_MASTERS-1:0]             m_stb_i,
    input  logic [N_MASTERS-1:0]             m_we_i,
    input  logic [N_MASTERS*(DATA_W/8)-1:0]  m_sel_i,
    input  logic [N_MASTERS*ADDR_W-1:0]      m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]      m_wdata_i,
    output logic [DATA_W-1:0]                m_rdata_o,
    output logic [N_MASTERS-1:0]             m_ack_o,
    output logic [N_MASTERS-1:0]             m_err_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [(DATA_W/8)-1:0]            s_sel_o,
    output logic [ADDR_W-1:0]                s_addr_o,
    output logic [DATA_W-1:0]                s_wdata_o,
    input  logic [DATA_W-1:0]                s_rdata_i,
    input  logic                             s_ack_i,
    output logic [N_MASTERS-1:0]             grant_o
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 2 || (DATA_W % 8) != 0) begin : g_cfg_check
        $error("wb_master_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWNED,
        ST_ABORT
    } state_t;

    state_t                 r_state;
    logic [N_MASTERS-1:0]   r_grant;
    logic [IDX_W-1:0]       r_last;
    logic [IDX_W-1:0]       r_owner;

    logic [IDX_W-1:0]       w_winner;
    logic [N_MASTERS-1:0]   w_winner_1h;
    logic                   w_found;
    logic                   w_owner_cyc;
    logic                   w_timeout;

    assign grant_o     = r_grant;
    assign m_rdata_o   = s_rdata_i;
    assign w_owner_cyc = m_cyc_i[r_owner];

    // Scan starts one past the previous owner so every requester is reached within N grants.
    always_comb begin
        logic [IDX_W-1:0] v_cand;
        w_found     = 1'b0;
        w_winner    = r_last;
        w_winner_1h = '0;
        v_cand      = '0;
        for (int unsigned i = 1; i <= N_MASTERS; i++) begin
            v_cand = IDX_W'((32'(r_last) + i) % N_MASTERS);
            if (!w_found && m_cyc_i[v_cand]) begin
                w_found  = 1'b1;
                w_winner = v_cand;
            end
        end
        w_winner_1h[w_winner] = 1'b1;
    end

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        m_ack_o   = '0;
        if (r_state == ST_OWNED) begin
            s_cyc_o   = m_cyc_i[r_owner];
            s_stb_o   = m_stb_i[r_owner];
            s_we_o    = m_we_i[r_owner];
            s_sel_o   = m_sel_i[r_owner*SEL_W +: SEL_W];
            s_addr_o  = m_addr_i[r_owner*ADDR_W +: ADDR_W];
            s_wdata_o = m_wdata_i[r_owner*DATA_W +: DATA_W];
            m_ack_o[r_owner] = s_ack_i & m_cyc_i[r_owner] & m_stb_i[r_owner];
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_state == ST_OWNED) && s_stb_o && !s_ack_i
                       && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign m_err_o   = r_grant & {N_MASTERS{w_timeout}};

    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if ((r_state == ST_IDLE && w_found) || s_ack_i) begin
            r_cnt <= '0;
        end else if (r_state == ST_OWNED && s_stb_o) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign m_err_o   = '0;
`endif

    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= IDX_W'(N_MASTERS - 1);
            r_owner <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_OWNED;
                        r_grant <= w_winner_1h;
                        r_owner <= w_winner;
                    end
                end
                ST_OWNED: begin
                    // Release wins over a coincident timeout: the owner is already gone.
                    if (!w_owner_cyc) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_last  <= r_owner;
                    end else if (w_timeout) begin
                        r_state <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    if (!w_owner_cyc) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_last  <= r_owner;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter (2 masters): cycle vector table plus round-robin, reset and
// watchdog sequences.
module tb_wb_master_arbiter;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [7:0]  m_sel;
    logic [63:0] m_addr, m_wdata;
    logic [31:0] m_rdata;
    logic [1:0]  m_ack, m_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_ack;
    logic [1:0]  grant;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    wb_master_arbiter #(
        .N_MASTERS(2),
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i (clk),
        .rst_i    (rst),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_we_i   (m_we),
        .m_sel_i  (m_sel),
        .m_addr_i (m_addr),
        .m_wdata_i(m_wdata),
        .m_rdata_o(m_rdata),
        .m_ack_o  (m_ack),
        .m_err_o  (m_err),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_sel_o  (s_sel),
        .s_addr_o (s_addr),
        .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata),
        .s_ack_i  (s_ack),
        .grant_o  (grant)
    );

    typedef struct {
        logic [1:0]  cyc, stb, we;
        logic        ack;
        logic [1:0]  grant;
        logic        scyc, sstb, swe;
        logic [1:0]  mack;
        logic [31:0] saddr;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        for (int k = 0; k < 8; k++) begin
            if (grant != 2'b00) break;
            tick();
        end
        if (grant == 2'b00) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no grant expected a grant within 8 cycles", name);
        end
    endtask

    function automatic logic [1:0] oh(input int idx);
        return 2'(1 << idx);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [3:0]  e_sel;
        logic [31:0] e_wdata;
        int          exp_owner;

        // cyc stb we ack | grant scyc sstb swe mack saddr
        vecs[0]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[1]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 32'h1000};
        vecs[2]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 32'h1000};
        vecs[3]  = '{2'b11, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 32'h1000};
        vecs[4]  = '{2'b10, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 32'h1000};
        vecs[5]  = '{2'b10, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[6]  = '{2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 32'h2000};
        vecs[7]  = '{2'b11, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 32'h2000};
        vecs[8]  = '{2'b11, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 2'b10, 32'h2000};
        vecs[9]  = '{2'b01, 2'b01, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 32'h2000};
        vecs[10] = '{2'b01, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[11] = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 32'h1000};
        vecs[12] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 32'h1000};
        vecs[13] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};

        m_addr  = {32'h0000_2000, 32'h0000_1000};
        m_wdata = {32'hA5A5_A5A5, 32'h1111_1111};
        m_sel   = {4'b0011, 4'b1111};
        s_rdata = 32'hCAFE_F00D;
        rst     = 1'b1;
        m_cyc   = 2'b11;
        m_stb   = 2'b11;
        m_we    = 2'b11;
        s_ack   = 1'b1;

        // Reset state with requests and ack present
        tick();
        tick();
        #3;
        check("rst grant", 32'(grant), 32'h0);
        check("rst s_cyc", 32'(s_cyc), 32'h0);
        check("rst s_stb", 32'(s_stb), 32'h0);
        check("rst s_addr", s_addr, 32'h0);
        check("rst m_ack", 32'(m_ack), 32'h0);
        check("rst m_err", 32'(m_err), 32'h0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            m_cyc = vecs[i].cyc;
            m_stb = vecs[i].stb;
            m_we  = vecs[i].we;
            s_ack = vecs[i].ack;
            e_sel   = (vecs[i].grant == 2'b01) ? 4'b1111 : (vecs[i].grant == 2'b10) ? 4'b0011 : 4'b0000;
            e_wdata = (vecs[i].grant == 2'b01) ? 32'h1111_1111 :
                      (vecs[i].grant == 2'b10) ? 32'hA5A5_A5A5 : 32'h0;
            #3;
            check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
            check($sformatf("v%0d s_cyc", i), 32'(s_cyc), 32'(vecs[i].scyc));
            check($sformatf("v%0d s_stb", i), 32'(s_stb), 32'(vecs[i].sstb));
            check($sformatf("v%0d s_we", i), 32'(s_we), 32'(vecs[i].swe));
            check($sformatf("v%0d m_ack", i), 32'(m_ack), 32'(vecs[i].mack));
            check($sformatf("v%0d s_addr", i), s_addr, vecs[i].saddr);
            check($sformatf("v%0d s_sel", i), 32'(s_sel), 32'(e_sel));
            check($sformatf("v%0d s_wdata", i), s_wdata, e_wdata);
            check($sformatf("v%0d m_err", i), 32'(m_err), 32'h0);
            if (vecs[i].ack) check($sformatf("v%0d m_rdata", i), m_rdata, 32'hCAFE_F00D);
            tick();
        end

        // Round robin with both masters requesting; master 0 owned last so master 1 is next
        exp_owner = 1;
        m_we = 2'b00;
        for (int t = 0; t < 8; t++) begin
            m_cyc = 2'b11;
            m_stb = 2'b11;
            s_ack = 1'b0;
            wait_grant($sformatf("rr%0d wait", t));
            check($sformatf("rr%0d grant", t), 32'(grant), 32'(oh(exp_owner)));
            s_ack = 1'b1;
            #3;
            check($sformatf("rr%0d m_ack", t), 32'(m_ack), 32'(oh(exp_owner)));
            tick();
            s_ack = 1'b0;
            m_cyc = ~oh(exp_owner);
            m_stb = ~oh(exp_owner);
            tick();
            check($sformatf("rr%0d idle gap", t), 32'(grant), 32'h0);
            exp_owner = 1 - exp_owner;
        end

        // Asynchronous reset mid-transfer, then master 0 wins again
        m_cyc = 2'b11;
        m_stb = 2'b11;
        wait_grant("rstmid wait");
        check("rstmid pre grant", 32'(grant), 32'h2);
        #3;
        check("rstmid pre s_cyc", 32'(s_cyc), 32'h1);
        rst = 1'b1;
        #1;
        check("rstmid s_cyc", 32'(s_cyc), 32'h0);
        check("rstmid s_stb", 32'(s_stb), 32'h0);
        check("rstmid s_addr", s_addr, 32'h0);
        check("rstmid grant", 32'(grant), 32'h0);
        tick();
        rst = 1'b0;
        wait_grant("postrst wait");
        check("postrst grant", 32'(grant), 32'h1);
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never acks: error pulse on the 16th stalled cycle, then abort until owner leaves
        m_cyc = 2'b01;
        m_stb = 2'b01;
        s_ack = 1'b0;
        wait_grant("to wait");
        check("to grant", 32'(grant), 32'h1);
        for (int k = 1; k <= int'(TO); k++) begin
            if (k == 2) begin
                m_cyc = 2'b11;
                m_stb = 2'b11;
            end
            #3;
            check($sformatf("to c%0d m_err", k), 32'(m_err), (k == int'(TO)) ? 32'h1 : 32'h0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            #3;
            check("abort s_cyc", 32'(s_cyc), 32'h0);
            check("abort s_stb", 32'(s_stb), 32'h0);
            check("abort m_err", 32'(m_err), 32'h0);
            check("abort grant", 32'(grant), 32'h1);
            tick();
        end
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tick();
        check("abort release", 32'(grant), 32'h0);
        tick();
        check("abort next owner", 32'(grant), 32'h2);
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
